bcd_digit_scanner: RTL and testbench

BCD_DIGIT_SCANNER -- requirements
Module: bcd_digit_scanner

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/bin2bcd_serial.sv | 85 ++++++++
 rtl/bcd_digit_scanner.sv | 115 +++++++++++
 tb/tb_bcd_digit_scanner.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed BCD display scanner:
// converter state encoding, blank code and the double-dabble digit adjust.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // A BCD digit of 5 or more would carry wrongly after the next shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one shift per clock, start/done handshake.
// state | meaning
// IDLE  | waiting for i_start, o_ready high
// SHIFT | one add-3/shift step per cycle, BIN_WIDTH steps total
// LOAD  | result stable on o_bcd/o_ovf, o_done high for this one cycle
module bin2bcd_serial
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [BIN_WIDTH-1:0]    i_bin,
  output logic                    o_ready,
  output logic                    o_done,
  output logic [NUM_DIGITS*4-1:0] o_bcd,
  output logic                    o_ovf
);

  localparam int          BCD_W   = NUM_DIGITS * 4;
  localparam int          CW      = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

  conv_state_e        r_state;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CW-1:0]      r_cnt;
  logic               r_ovf;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic               w_ovf_in;

  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_bcd_adj[i*4 +: 4] = dd_adjust(r_bcd[i*4 +: 4]);
    end
  end

  assign w_ovf_in = (64'(i_bin) > MAX_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_bin   <= i_bin;
            r_bcd   <= '0;
            r_cnt   <= CW'(BIN_WIDTH);
            r_ovf   <= w_ovf_in;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Digits that overflow the top BCD nibble are lost; r_ovf blanks them later.
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready = (r_state == ST_IDLE);
  assign o_done  = (r_state == ST_LOAD);
  assign o_bcd   = r_bcd;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/bcd_digit_scanner.sv
// Binary-to-BCD multiplexed display driver with free-running digit scan.
// Optional leading-zero blanking is built when LEADING_ZERO_BLANK_EN is defined.
module bcd_digit_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  value_valid,
  input  logic [BIN_WIDTH-1:0]  value,
  output logic                  value_ready,
  output logic [3:0]            number,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  overflow
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic                          w_ready;
  logic                          w_start;
  logic                          w_done;
  logic [NUM_DIGITS*4-1:0]       w_bcd;
  logic                          w_ovf;
  logic [NUM_DIGITS-1:0][3:0]    w_disp_load;
  logic [NUM_DIGITS-1:0][3:0]    w_disp_eff;
  logic                          w_wrap;
  logic [IDX_W-1:0]              w_idx_next;

  logic [PW-1:0]                 r_presc;
  logic [IDX_W-1:0]              r_idx;
  logic [NUM_DIGITS-1:0][3:0]    r_disp;
  logic [3:0]                    r_number;
  logic [NUM_DIGITS-1:0]         r_digit_en;
  logic                          r_ovf;

  assign w_start = value_valid & w_ready;

  bin2bcd_serial #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_WIDTH  (BIN_WIDTH)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_bin   (value),
    .o_ready (w_ready),
    .o_done  (w_done),
    .o_bcd   (w_bcd),
    .o_ovf   (w_ovf)
  );

  always_comb begin : p_blank
`ifdef LEADING_ZERO_BLANK_EN
    logic v_seen;
    v_seen = 1'b0;
`endif
    w_disp_load = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_disp_load[i] = w_bcd[i*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      // Digit 0 always shows, so a zero value reads as a single 0.
      if (i != 0 && !v_seen && w_bcd[i*4 +: 4] == 4'h0) begin
        w_disp_load[i] = BLANK_CODE;
      end
      if (w_bcd[i*4 +: 4] != 4'h0) begin
        v_seen = 1'b1;
      end
`endif
      if (w_ovf) begin
        w_disp_load[i] = BLANK_CODE;
      end
    end
  end

  // Bypass lets a same-edge display update reach the output mux without a cycle of stale data.
  assign w_disp_eff = w_done ? w_disp_load : r_disp;
  assign w_wrap     = (r_presc == PW'(REFRESH_DIV - 1));

  always_comb begin
    w_idx_next = r_idx;
    if (w_wrap) begin
      w_idx_next = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_disp     <= '0;
      r_number   <= 4'h0;
      r_digit_en <= ~NUM_DIGITS'(1);
      r_ovf      <= 1'b0;
    end else begin
      r_presc    <= w_wrap ? '0 : r_presc + PW'(1);
      r_idx      <= w_idx_next;
      r_number   <= w_disp_eff[w_idx_next];
      r_digit_en <= ~(NUM_DIGITS'(1) << w_idx_next);
      if (w_done) begin
        r_disp <= w_disp_load;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign value_ready = w_ready;
  assign number      = r_number;
  assign digit_en    = r_digit_en;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed self-checking bench for bcd_digit_scanner (4 digits, 14-bit input, refresh 4).
module tb_bcd_digit_scanner;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          value_valid = 1'b0;
  logic [BW-1:0] value = '0;
  logic          value_ready;
  logic [3:0]    number;
  logic [ND-1:0] digit_en;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_digit_scanner #(
    .NUM_DIGITS  (ND),
    .BIN_WIDTH   (BW),
    .REFRESH_DIV (RD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_valid (value_valid),
    .value       (value),
    .value_ready (value_ready),
    .number      (number),
    .digit_en    (digit_en),
    .overflow    (overflow)
  );

  // Expected display digits, digit 0 in bits [3:0].
  function automatic logic [15:0] model(input int v);
    logic [15:0] r;
`ifdef LEADING_ZERO_BLANK_EN
    bit seen;
`endif
    if (v > 9999) return 16'hFFFF;
    r = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef LEADING_ZERO_BLANK_EN
    seen = 0;
    for (int i = 3; i >= 1; i--) begin
      if (!seen && r[i*4 +: 4] == 4'h0) r[i*4 +: 4] = 4'hF;
      else seen = 1;
    end
`endif
    return r;
  endfunction

  function automatic int idx_of(input logic [3:0] en);
    case (en)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic read_all(output logic [15:0] got, output bit ok);
    ok  = 1;
    got = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      bit found;
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk);
        if (idx_of(digit_en) == i) begin
          found = 1;
          got[i*4 +: 4] = number;
        end
      end
      if (!found) ok = 0;
    end
  endtask

  task automatic send(input logic [BW-1:0] v, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (value_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (value_ready === 1'b1);
    value_valid = 1'b1;
    value       = v;
    @(posedge clk);
    #1 value_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (value_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (value_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (value_ready !== 1'b1 || number !== 4'h0 || digit_en !== 4'b1110 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ready=%b number=%h en=%b ovf=%b, want 1 0 1110 0",
               value_ready, number, digit_en, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (digit_en !== 4'b1110 || number !== 4'h0) begin
      bad++;
      $display("FAIL scan_hold3: en=%b number=%h, want 1110 0", digit_en, number);
    end
    @(posedge clk);
    #1;
    total++;
    if (digit_en !== 4'b1101 || number !== 4'h0) begin
      bad++;
      $display("FAIL scan_adv4: en=%b number=%h, want 1101 0", digit_en, number);
    end
    repeat (12) @(posedge clk);
    #1;
    total++;
    if (digit_en !== 4'b1110 || value_ready !== 1'b1) begin
      bad++;
      $display("FAIL scan_wrap16: en=%b ready=%b, want 1110 1", digit_en, value_ready);
    end
  endtask

  task automatic test_convert_1234();
    bit ok;
    int lows;
    int id;
    logic [15:0] got;
    logic [15:0] exp;
    exp = model(1234);
    send(14'd1234, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL c1234_send: ready never high");
    end
    lows = (value_ready === 1'b0) ? 1 : 0;
    for (int k = 1; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (value_ready === 1'b0) lows++;
      if (k == 14) begin
        total++;
        if (number !== 4'h0) begin
          bad++;
          $display("FAIL c1234_early: number=%h before update, want 0", number);
        end
      end
    end
    total++;
    if (lows != 15) begin
      bad++;
      $display("FAIL c1234_ready_low: low cycles=%0d, want 15", lows);
    end
    @(posedge clk);
    #1;
    id = idx_of(digit_en);
    total++;
    if (value_ready !== 1'b1 || id < 0 || number !== exp[id*4 +: 4] || overflow !== 1'b0) begin
      bad++;
      $display("FAIL c1234_update: ready=%b en=%b number=%h ovf=%b, want ready 1 ovf 0 digit of %h",
               value_ready, digit_en, number, overflow, exp);
    end
    read_all(got, ok);
    total++;
    if (!ok || got !== exp) begin
      bad++;
      $display("FAIL c1234_digits: got=%h ok=%0d, want %h", got, ok, exp);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    bit ok2;
    logic [15:0] got;
    int vals [3];
    logic exp_ovf [3];
    vals[0] = 9999;  exp_ovf[0] = 1'b0;
    vals[1] = 10000; exp_ovf[1] = 1'b1;
    vals[2] = 0;     exp_ovf[2] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      send(BW'(vals[t]), ok);
      wait_idle(ok2);
      read_all(got, ok);
      total++;
      if (!ok || !ok2 || got !== model(vals[t]) || overflow !== exp_ovf[t]) begin
        bad++;
        $display("FAIL ovf_%0d: digits=%h ovf=%b, want %h %b",
                 vals[t], got, overflow, model(vals[t]), exp_ovf[t]);
      end
    end
  endtask

  task automatic test_no_queue();
    bit ok;
    int n;
    int id;
    logic [15:0] e42;
    logic [15:0] got;
    e42 = model(42);
    send(14'd42, ok);
    repeat (3) @(posedge clk);
    @(negedge clk);
    value_valid = 1'b1;
    value       = 14'd7;
    n = 0;
    while (value_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (value_ready !== 1'b1) begin
      bad++;
      $display("FAIL nq_ready_timeout: ready=%b, want 1", value_ready);
    end
    for (int k = 0; k < 16; k++) begin
      id = idx_of(digit_en);
      total++;
      if (id < 0 || number !== e42[id*4 +: 4]) begin
        bad++;
        $display("FAIL nq_shows42: en=%b number=%h, want digit of %h", digit_en, number, e42);
      end
      @(negedge clk);
      if (k == 0) begin
        value_valid = 1'b0;
        total++;
        if (value_ready !== 1'b0) begin
          bad++;
          $display("FAIL nq_accept7: ready=%b, want 0", value_ready);
        end
      end
    end
    wait_idle(ok);
    read_all(got, ok);
    total++;
    if (!ok || got !== model(7)) begin
      bad++;
      $display("FAIL nq_digits7: got=%h, want %h", got, model(7));
    end
  endtask

  task automatic test_leading_zero();
    bit ok;
    logic [15:0] got;
    logic [15:0] exp;
`ifdef LEADING_ZERO_BLANK_EN
    exp = 16'hFFF5;
`else
    exp = 16'h0005;
`endif
    send(14'd5, ok);
    wait_idle(ok);
    read_all(got, ok);
    total++;
    if (!ok || got !== exp || overflow !== 1'b0) begin
      bad++;
      $display("FAIL lz_5: got=%h ovf=%b, want %h 0", got, overflow, exp);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int errs;
    send(14'd8765, ok);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (value_ready !== 1'b1 || number !== 4'h0 || digit_en !== 4'b1110 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL rm_async: ready=%b number=%h en=%b ovf=%b, want 1 0 1110 0",
               value_ready, number, digit_en, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (number !== 4'h0 || value_ready !== 1'b1 || overflow !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL rm_no_update: bad cycles=%0d, want 0", errs);
    end
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_overflow();
    test_no_queue();
    test_leading_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
